can_opb_arbiter: RTL and testbench
==================================

Name: can_opb_arbiter

Overview:
- Round-robin arbiter and access sequencer that shares the single OPB register port of the quad-CAN interface between NREQ requesters (CPU bridge, status poller, DMA).
- Accepts one request at a time and drives the registered one-cycle CAN_RE/CAN_WE strobe with address and write data.
- Captures read data after a fixed read latency and returns a one-cycle ACK to the granted requester.
- Sits between the OPB slave decode and the CAN interface block.

Parameters:
- NREQ, 4, number of requesters (2..8).
- RD_LAT, 2, clocks from strobe assertion to valid CAN_RDATA (1..7).
- AW, 32, address width.

Ports:
- OPB_CLK  in  1  system clock; all logic on rising edge.
- OPB_RST  in  1  asynchronous, active-high reset.
- REQ  in  NREQ  per-requester access request (level, held until ACK).
- REQ_WR  in  NREQ  1 = write, 0 = read, per requester.
- REQ_ADDR  in  NREQ*AW  flattened addresses; requester i at [i*AW +: AW].
- REQ_WDATA  in  NREQ*32  flattened write data.
- GNT  out  NREQ  one-hot owner of current access; all zero when idle.
- ACK  out  NREQ  one-cycle completion pulse to the owner.
- ERR  out  1  valid with ACK; 1 = access rejected (see Optional Feature).
- RDATA  out  32  read data; valid in the ACK cycle of a read, holds until next read ACK.
- CAN_ADDR  out  AW  address to CAN interface.
- CAN_WDATA  out  32  write data to CAN interface.
- CAN_RE  out  1  read strobe, one clock.
- CAN_WE  out  1  write strobe, one clock.
- CAN_RDATA  in  32  read data from CAN interface.

Behaviour:
- Reset values: GNT=0, ACK=0, ERR=0, RDATA=0, CAN_ADDR=0, CAN_WDATA=0, CAN_RE=0, CAN_WE=0, state IDLE, rr_ptr=NREQ-1 (requester 0 wins first).
- All outputs are registered.
- States: IDLE, STROBE, WAIT, DONE.
- IDLE:
  - If any REQ bit is set, pick the first set bit searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Set GNT one-hot and rr_ptr = winner.
  - Latch the winner's REQ_WR, REQ_ADDR and REQ_WDATA.
  - Go to STROBE.
  - Bits of REQ that drop without an ACK are ignored.
- STROBE (cycle c): CAN_RE or CAN_WE = 1 for exactly this cycle; CAN_ADDR/CAN_WDATA show the latched values.
  - Write: go to DONE.
  - Read with RD_LAT=1: capture CAN_RDATA at the edge ending c; go to DONE.
  - Read with RD_LAT>1: load lat_cnt = RD_LAT-1; go to WAIT.
- WAIT: decrement lat_cnt each clock. When lat_cnt reaches 1, capture CAN_RDATA into RDATA at that edge (the edge ending cycle c+RD_LAT-1) and go to DONE.
- DONE: ACK[owner]=1 for one cycle and ERR as computed; GNT is held. Next state is IDLE with GNT cleared.
- CAN_ADDR and CAN_WDATA hold their last values after the strobe (no return to zero).
- Latency from the IDLE cycle that sees REQ to the ACK cycle:
  - write = 2 clocks
  - read = RD_LAT+1 clocks (3 at default).
- Back-to-back accesses:
  - Minimum spacing between strobes = write 3 clocks, read RD_LAT+2 clocks.
  - A registered requester drops REQ on the ACK edge, so the following IDLE cycle never re-grants the same access.
  - A REQ still high in that IDLE cycle is a new access.
- Simultaneous requests: strict round-robin.
  - With all NREQ bits held high, grants cycle 0,1,2,3,0...
  - No requester waits more than NREQ-1 accesses.
- REQ changing while not granted has no effect on the access in flight.
- Reset mid-access: all strobes, GNT and ACK drop asynchronously; the access is lost, no ACK is issued; RDATA=0.
- CAN_RE and CAN_WE are never high together; at most one GNT bit is set.

Optional Feature:
- Macro CAN_ARB_ADDR_CHK_EN.
- When defined, IDLE checks the latched address bits [14:11] for exactly one set bit (CAN1 0x0800, CAN2 0x1000, CAN3 0x2000, CAN4 0x4000 windows).
  - Non-one-hot value (e.g. 0x0000, 0x1800, 0x6000): skip STROBE/WAIT, no CAN_RE/CAN_WE, go straight to DONE with ERR=1 and RDATA unchanged. Latency is 2 clocks.
- When undefined, every address is forwarded unchecked and ERR is tied to 0.

Test Plan:
- Reset release, REQ[0]=1 write to 0x00000800 data 0x12345678:
  - CAN_WE high exactly 1 clock with CAN_ADDR=0x800 and CAN_WDATA=0x12345678.
  - ACK[0] 2 clocks after REQ seen; ERR=0.
- REQ[1] read 0x00001000, model returns 0xAABBCCDD 2 clocks after CAN_RE: RDATA=0xAABBCCDD with ACK[1] 3 clocks after request; CAN_RE high 1 clock.
- REQ=4'b1111 held with all reads: grant order 0,1,2,3,0; ACK spacing 4 clocks; GNT always one-hot; CAN_RE/CAN_WE never overlap.
- OPB_RST asserted during WAIT of a read: CAN_RE/GNT go 0 immediately; no ACK; after release, REQ[2] is granted first (rr_ptr reset).
- With CAN_ARB_ADDR_CHK_EN, read 0x00001800: no strobe, ACK with ERR=1 after 2 clocks, RDATA unchanged. Without the macro, the same access strobes CAN_RE and ERR=0.
- RD_LAT=4 build, read with data valid 4 clocks after strobe: RDATA captured correctly; ACK 5 clocks after request.

Source files
------------

// File: rtl/can_opb_arbiter.sv
// can_opb_arbiter: round-robin sharing of the quad-CAN OPB register port.
// One access at a time: grant, one-clock CAN_RE/CAN_WE strobe, optional wait
// for read data, then a one-clock ACK to the owner.
// Optional build macro CAN_ARB_ADDR_CHK_EN: reject addresses whose bits
// [14:11] do not select exactly one CAN window (ERR=1, no strobe).
module can_opb_arbiter #(
   parameter int NREQ   = 4,
   parameter int RD_LAT = 2,
   parameter int AW     = 32
) (
   input  logic                 OPB_CLK,
   input  logic                 OPB_RST,
   input  logic [NREQ-1:0]      REQ,
   input  logic [NREQ-1:0]      REQ_WR,
   input  logic [NREQ*AW-1:0]   REQ_ADDR,
   input  logic [NREQ*32-1:0]   REQ_WDATA,
   output logic [NREQ-1:0]      GNT,
   output logic [NREQ-1:0]      ACK,
   output logic                 ERR,
   output logic [31:0]          RDATA,
   output logic [AW-1:0]        CAN_ADDR,
   output logic [31:0]          CAN_WDATA,
   output logic                 CAN_RE,
   output logic                 CAN_WE,
   input  logic [31:0]          CAN_RDATA
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   rr_ptr;
   logic [PW-1:0]   winner;
   logic            found;
   logic [NREQ-1:0] gnt;
   logic [NREQ-1:0] ack;
   logic            err;
   logic [31:0]     rdata;
   logic [AW-1:0]   can_addr;
   logic [31:0]     can_wdata;
   logic            can_re;
   logic            can_we;
   logic            acc_wr;
   logic            acc_err;
   logic [2:0]      lat_cnt;
   logic            addr_bad;
   logic            enter_done;
   logic [AW-1:0]   addr_arr  [NREQ];
   logic [31:0]     wdata_arr [NREQ];
   logic [AW-1:0]   win_addr;
   logic [31:0]     win_wdata;

   for (genvar g = 0; g < NREQ; g++) begin : g_split
      assign addr_arr[g]  = REQ_ADDR[g*AW +: AW];
      assign wdata_arr[g] = REQ_WDATA[g*32 +: 32];
   end

   assign win_addr  = addr_arr[winner];
   assign win_wdata = wdata_arr[winner];

`ifdef CAN_ARB_ADDR_CHK_EN
   logic [3:0] win_sel;
   assign win_sel  = win_addr[14:11];
   assign addr_bad = !((win_sel != 4'd0) && ((win_sel & (win_sel - 4'd1)) == 4'd0));
`else
   assign addr_bad = 1'b0;
`endif

   // Round-robin search: first set REQ bit after the last winner, wrapping.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      for (int k = 1; k <= NREQ; k++) begin
         int            idx;
         logic [PW-1:0] idx_pw;
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         idx_pw = PW'(idx);
         if (!found && REQ[idx_pw]) begin
            found  = 1'b1;
            winner = idx_pw;
         end
      end
   end

   // State register.
   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) state <= IDLE;
      else         state <= state_next;
   end

   // Next-state logic; rejected accesses and writes skip the read wait.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:   if (found) state_next = STROBE;
         STROBE: begin
            if (acc_err || acc_wr || (RD_LAT == 1)) state_next = DONE;
            else                                    state_next = WAIT;
         end
         WAIT:   if (lat_cnt == 3'd1) state_next = DONE;
         DONE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign enter_done = (state != DONE) && (state_next == DONE);

   // Registered grant, strobes, address/data, read capture and ACK/ERR.
   always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
      if (OPB_RST) begin
         rr_ptr    <= PW'(NREQ - 1);
         gnt       <= '0;
         ack       <= '0;
         err       <= 1'b0;
         rdata     <= '0;
         can_addr  <= '0;
         can_wdata <= '0;
         can_re    <= 1'b0;
         can_we    <= 1'b0;
         acc_wr    <= 1'b0;
         acc_err   <= 1'b0;
         lat_cnt   <= '0;
      end else begin
         can_re <= 1'b0;
         can_we <= 1'b0;
         ack    <= enter_done ? gnt : '0;
         err    <= enter_done && acc_err;
         case (state)
            IDLE: begin
               if (found) begin
                  gnt     <= NREQ'(1) << winner;
                  rr_ptr  <= winner;
                  acc_wr  <= REQ_WR[winner];
                  acc_err <= addr_bad;
                  if (!addr_bad) begin
                     can_addr  <= win_addr;
                     can_wdata <= win_wdata;
                     can_re    <= !REQ_WR[winner];
                     can_we    <= REQ_WR[winner];
                  end
               end
            end
            STROBE: begin
               if (!acc_err && !acc_wr) begin
                  if (RD_LAT == 1) rdata   <= CAN_RDATA;
                  else             lat_cnt <= 3'(RD_LAT - 1);
               end
            end
            WAIT: begin
               if (lat_cnt == 3'd1) rdata   <= CAN_RDATA;
               else                 lat_cnt <= lat_cnt - 3'd1;
            end
            DONE: gnt <= '0;
            default: ;
         endcase
      end
   end

   assign GNT       = gnt;
   assign ACK       = ack;
   assign ERR       = err;
   assign RDATA     = rdata;
   assign CAN_ADDR  = can_addr;
   assign CAN_WDATA = can_wdata;
   assign CAN_RE    = can_re;
   assign CAN_WE    = can_we;

endmodule

// File: tb/tb_can_opb_arbiter.sv
// tb_can_opb_arbiter: scoreboard bench for can_opb_arbiter.
// Stimulus pushes expected strobes and ACKs into queues; a monitor pops and
// compares them whenever the DUT strobes or acknowledges.
module tb_can_opb_arbiter;

   localparam int NREQ   = 4;
   localparam int RD_LAT = 2;
   localparam int AW     = 32;

   logic                OPB_CLK = 1'b0;
   logic                OPB_RST;
   logic [NREQ-1:0]     REQ;
   logic [NREQ-1:0]     REQ_WR;
   logic [NREQ*AW-1:0]  REQ_ADDR;
   logic [NREQ*32-1:0]  REQ_WDATA;
   logic [NREQ-1:0]     GNT;
   logic [NREQ-1:0]     ACK;
   logic                ERR;
   logic [31:0]         RDATA;
   logic [AW-1:0]       CAN_ADDR;
   logic [31:0]         CAN_WDATA;
   logic                CAN_RE;
   logic                CAN_WE;
   logic [31:0]         CAN_RDATA;

   typedef struct {
      int          idx;
      logic        err;
      logic        chk_rd;
      logic [31:0] rdata;
      int          cyc;
   } ack_exp_t;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          cyc;
   } stb_exp_t;

   ack_exp_t ack_q[$];
   stb_exp_t stb_q[$];

   int checks    = 0;
   int failures  = 0;
   int cyc       = 0;
   int ack_count = 0;

   logic [6:0] re_pipe;
   logic [7:0] re_line;

   can_opb_arbiter #(.NREQ(NREQ), .RD_LAT(RD_LAT), .AW(AW)) dut (
      .OPB_CLK   (OPB_CLK),
      .OPB_RST   (OPB_RST),
      .REQ       (REQ),
      .REQ_WR    (REQ_WR),
      .REQ_ADDR  (REQ_ADDR),
      .REQ_WDATA (REQ_WDATA),
      .GNT       (GNT),
      .ACK       (ACK),
      .ERR       (ERR),
      .RDATA     (RDATA),
      .CAN_ADDR  (CAN_ADDR),
      .CAN_WDATA (CAN_WDATA),
      .CAN_RE    (CAN_RE),
      .CAN_WE    (CAN_WE),
      .CAN_RDATA (CAN_RDATA)
   );

   // 100 MHz clock.
   always #5 OPB_CLK = ~OPB_CLK;

   // Free-running cycle counter used to time strobes and ACKs.
   always @(posedge OPB_CLK) cyc <= cyc + 1;

   // CAN slave model: read data valid RD_LAT clocks after the strobe edge.
   function automatic logic [31:0] slave_word(input logic [31:0] a);
      if (a == 32'h0000_1000) return 32'hAABB_CCDD;
      return {a[15:0], ~a[15:0]};
   endfunction

   always @(posedge OPB_CLK) begin
      if (OPB_RST) re_pipe <= '0;
      else         re_pipe <= {re_pipe[5:0], CAN_RE};
   end

   assign re_line   = {re_pipe, CAN_RE};
   assign CAN_RDATA = re_line[RD_LAT-1] ? slave_word(CAN_ADDR) : 32'hDEAD_BEEF;

   task automatic check_output(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Monitor: invariants every cycle, strobe and ACK scoreboard checks.
   always @(negedge OPB_CLK) begin
      stb_exp_t s;
      ack_exp_t a;
      if (!OPB_RST) begin
         check_output("re_we_exclusive", 64'(CAN_RE & CAN_WE), 64'd0);
         check_output("gnt_onehot0", 64'($onehot0(GNT)), 64'd1);
         if (CAN_RE || CAN_WE) begin
            if (stb_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_strobe: got RE=%b WE=%b, expected none", CAN_RE, CAN_WE);
            end else begin
               s = stb_q.pop_front();
               check_output("strobe_we", 64'(CAN_WE), 64'(s.wr));
               check_output("strobe_re", 64'(CAN_RE), 64'(!s.wr));
               check_output("strobe_addr", 64'(CAN_ADDR), 64'(s.addr));
               if (s.wr) check_output("strobe_wdata", 64'(CAN_WDATA), 64'(s.wdata));
               check_output("strobe_cycle", 64'(cyc), 64'(s.cyc));
            end
         end
         if (ACK != '0) begin
            ack_count++;
            if (ack_q.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL unexpected_ack: got ACK=%b, expected none", ACK);
            end else begin
               a = ack_q.pop_front();
               check_output("ack_owner", 64'(ACK), 64'(NREQ'(1) << a.idx));
               check_output("gnt_at_ack", 64'(GNT), 64'(NREQ'(1) << a.idx));
               check_output("ack_err", 64'(ERR), 64'(a.err));
               if (a.chk_rd) check_output("ack_rdata", 64'(RDATA), 64'(a.rdata));
               check_output("ack_cycle", 64'(cyc), 64'(a.cyc));
            end
         end
      end
   end

   // Issue one access in an IDLE cycle and queue its expected strobe and ACK.
   task automatic apply_stimulus(input int idx, input logic wr, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic err,
                                 input logic [31:0] exp_rd, input logic strobe);
      int lat;
      @(negedge OPB_CLK);
      #1;
      REQ_WR[idx]              = wr;
      REQ_ADDR[idx*AW +: AW]   = addr;
      REQ_WDATA[idx*32 +: 32]  = wdata;
      REQ[idx]                 = 1'b1;
      lat = (strobe && !wr) ? RD_LAT + 1 : 2;
      if (strobe) stb_q.push_back('{wr, addr, wdata, cyc + 1});
      ack_q.push_back('{idx, err, !wr, exp_rd, cyc + lat});
   endtask

   // Wait (bounded) for n more ACKs, then withdraw all requests.
   task automatic wait_acks(input int n, input int budget);
      int target;
      int k;
      target = ack_count + n;
      k = 0;
      while (ack_count < target && k < budget) begin
         @(negedge OPB_CLK);
         #1;
         k++;
      end
      checks++;
      if (ack_count < target) begin
         failures++;
         $display("[TB] FAIL ack_timeout: got %0d acks, expected %0d", ack_count, target);
      end
      REQ = '0;
   endtask

   task automatic do_reset();
      @(negedge OPB_CLK);
      #1;
      OPB_RST = 1'b1;
      REQ     = '0;
      ack_q.delete();
      stb_q.delete();
      repeat (2) @(negedge OPB_CLK);
      #1;
      OPB_RST = 1'b0;
   endtask

   // Directed test sequence.
   initial begin
      logic [31:0] rr_addr [4];
      logic [31:0] rr_data [4];
      int          n;
      rr_addr = '{32'h0000_0800, 32'h0000_1000, 32'h0000_2000, 32'h0000_4000};
      rr_data = '{32'h0800_F7FF, 32'hAABB_CCDD, 32'h2000_DFFF, 32'h4000_BFFF};

      OPB_RST   = 1'b1;
      REQ       = '0;
      REQ_WR    = '0;
      REQ_ADDR  = '0;
      REQ_WDATA = '0;
      repeat (3) @(negedge OPB_CLK);
      check_output("rst_gnt",   64'(GNT),       64'd0);
      check_output("rst_ack",   64'(ACK),       64'd0);
      check_output("rst_err",   64'(ERR),       64'd0);
      check_output("rst_rdata", 64'(RDATA),     64'd0);
      check_output("rst_addr",  64'(CAN_ADDR),  64'd0);
      check_output("rst_wdata", 64'(CAN_WDATA), 64'd0);
      check_output("rst_re",    64'(CAN_RE),    64'd0);
      check_output("rst_we",    64'(CAN_WE),    64'd0);
      #1;
      OPB_RST = 1'b0;

      $display("[TB] write from requester 0");
      apply_stimulus(0, 1'b1, 32'h0000_0800, 32'h1234_5678, 1'b0, 32'h0, 1'b1);
      wait_acks(1, 20);

      $display("[TB] read from requester 1");
      apply_stimulus(1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 32'hAABB_CCDD, 1'b1);
      wait_acks(1, 20);

      $display("[TB] round robin with all requesters reading");
      do_reset();
      @(negedge OPB_CLK);
      #1;
      for (int i = 0; i < 4; i++) begin
         REQ_WR[i]            = 1'b0;
         REQ_ADDR[i*AW +: AW] = rr_addr[i];
      end
      REQ = 4'b1111;
      n = cyc;
      for (int k = 0; k < 5; k++) begin
         stb_q.push_back('{1'b0, rr_addr[k % 4], 32'h0, n + 1 + k * (RD_LAT + 2)});
         ack_q.push_back('{k % 4, 1'b0, 1'b1, rr_data[k % 4], n + RD_LAT + 1 + k * (RD_LAT + 2)});
      end
      wait_acks(5, 100);

      $display("[TB] reset during read wait");
      apply_stimulus(1, 1'b0, 32'h0000_1000, 32'h0, 1'b0, 32'hAABB_CCDD, 1'b1);
      @(negedge OPB_CLK);
      @(negedge OPB_CLK);
      #1;
      OPB_RST = 1'b1;
      REQ     = '0;
      ack_q.delete();
      stb_q.delete();
      #1;
      check_output("midrst_re",    64'(CAN_RE), 64'd0);
      check_output("midrst_gnt",   64'(GNT),    64'd0);
      check_output("midrst_ack",   64'(ACK),    64'd0);
      check_output("midrst_rdata", 64'(RDATA),  64'd0);
      repeat (3) @(negedge OPB_CLK);
      #1;
      OPB_RST = 1'b0;
      apply_stimulus(2, 1'b0, 32'h0000_2000, 32'h0, 1'b0, 32'h2000_DFFF, 1'b1);
      wait_acks(1, 20);

      $display("[TB] access to address 0x1800");
`ifdef CAN_ARB_ADDR_CHK_EN
      apply_stimulus(3, 1'b0, 32'h0000_1800, 32'h0, 1'b1, 32'h2000_DFFF, 1'b0);
`else
      apply_stimulus(3, 1'b0, 32'h0000_1800, 32'h0, 1'b0, 32'h1800_E7FF, 1'b1);
`endif
      wait_acks(1, 20);

      repeat (3) @(negedge OPB_CLK);
      check_output("ack_queue_empty",    64'(ack_q.size()), 64'd0);
      check_output("strobe_queue_empty", 64'(stb_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

   // Safety net in case the sequence ever stalls.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got no completion, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
